// File: rtl/seg7_scan_driver_if.sv
// Bus between a value source and the multiplexed 7-segment scan driver.
`timescale 1ns/1ps
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                pending;
    logic                frame_start;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [DIGITS-1:0]   digit_sel;

    // Source side: supplies the value and load strobe, observes display status.
    modport master (
        output value_in, dp_in, load,
        input  pending, frame_start, seg_out, dp_out, digit_sel
    );

    // Driver side.
    modport slave (
        input  value_in, dp_in, load,
        output pending, frame_start, seg_out, dp_out, digit_sel
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, per-slot blanking,
// leading-zero suppression and a frame-aligned double buffer for the shown value.
`timescale 1ns/1ps
module seg7_scan_driver #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          BLANK_LZ     = 1'b1,
    parameter bit          SEG_ACT_LOW  = 1'b0,
    parameter bit          DIG_ACT_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  pend_val;
    logic [DIGITS-1:0] pend_dp;
    logic [VAL_W-1:0]  disp_val;
    logic [DIGITS-1:0] disp_dp;
    logic              pend_flag;
    logic              wrap;

    logic [VAL_W-1:0]  upper;
    logic              in_blank;
    logic              suppressed;
    logic [6:0]        seg_raw;
    logic              dp_raw;
    logic [DIGITS-1:0] sel_raw;

    // Active-high segment pattern (gfedcba) for one hex nibble.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
        endcase
        return pat;
    endfunction

    assign wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Slot prescaler and active-digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: a load waits in pend and is promoted only on the frame wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pend_flag <= 1'b0;
        end else if (wrap && bus.load) begin
            disp_val  <= bus.value_in;
            disp_dp   <= bus.dp_in;
            pend_flag <= 1'b0;
        end else if (wrap && pend_flag) begin
            disp_val  <= pend_val;
            disp_dp   <= pend_dp;
            pend_flag <= 1'b0;
        end else if (bus.load) begin
            pend_val  <= bus.value_in;
            pend_dp   <= bus.dp_in;
            pend_flag <= 1'b1;
        end
    end

    // Decode the active digit; held reset forces every output to its off level.
    always_comb begin
        seg_raw    = 7'h00;
        dp_raw     = 1'b0;
        sel_raw    = '0;
        upper      = disp_val >> {idx, 2'b00};
        in_blank   = (32'(cnt) + 32'd1) <= BLANK_CYCLES;
        suppressed = BLANK_LZ && (idx != '0) && (upper == '0);
        if (rst_n && !in_blank) begin
            sel_raw = DIGITS'(1) << idx;
            seg_raw = suppressed ? 7'h00 : decode_hex(upper[3:0]);
            dp_raw  = disp_dp[idx];
        end
    end

    assign bus.seg_out     = seg_raw ^ {7{SEG_ACT_LOW}};
    assign bus.dp_out      = dp_raw ^ SEG_ACT_LOW;
    assign bus.digit_sel   = sel_raw ^ {DIGITS{DIG_ACT_LOW}};
    assign bus.frame_start = rst_n && wrap;
    assign bus.pending     = pend_flag;
endmodule
